// File: rtl/mult_pkg.sv
// Shared constants and types for the 32x32 multiplier datapath.
// The cs_final_adder build option MULT_HI_EN selects a full 64-bit or a low 32-bit resolve.
package mult_pkg;

  localparam int PROD_W = 64;
  localparam int C_W    = 63;
  localparam int S_W    = 64;
  localparam int LOW_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A slice never exceeds the span being resolved (CHUNK_W=64 on a 32-bit span gives one slice).
  function automatic int slice_width(input int chunk_w, input int span_w);
    return (chunk_w < span_w) ? chunk_w : span_w;
  endfunction

endpackage

// File: rtl/cfa_chunk_add.sv
// Combinational W-bit adder with carry-in and carry-out; one slice of the final adder.
module cfa_chunk_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign sum   = total[W-1:0];
  assign cout  = total[W];

endmodule

// File: rtl/cs_final_adder.sv
// Sequential carry-propagate adder turning the compressor's carry/sum pair into a binary product.
// Define MULT_HI_EN to resolve all 64 bits; otherwise only bits 31:0 are added and prod[63:32] = 0.
module cs_final_adder
  import mult_pkg::*;
#(
  parameter int CHUNK_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [C_W-1:0]    c_in,
  input  logic [S_W-1:0]    s_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] prod
);

`ifdef MULT_HI_EN
  localparam int RES_W = PROD_W;
`else
  localparam int RES_W = LOW_W;
`endif
  localparam int SLICE_W = slice_width(CHUNK_W, RES_W);
  localparam int NCHUNK  = RES_W / SLICE_W;
  localparam int IDX_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // ready never depends combinationally on the partner's valid.

  state_t             state_q, state_d;
  logic [RES_W-1:0]   s_q, a_q, res_q;
  logic               carry_q;
  logic [IDX_W-1:0]   idx_q;
  logic [PROD_W-1:0]  a_full;
  logic [31:0]        base;
  logic [SLICE_W-1:0] s_slice, a_slice, sum_slice;
  logic               cout;
  logic               accept;
  logic               last_slice;

  assign a_full     = {c_in, 1'b0};
  assign in_ready   = (state_q == IDLE) & ~rst;
  assign accept     = in_ready & in_valid;
  assign last_slice = (idx_q == LAST_IDX);
  assign out_valid  = (state_q == DONE);

`ifdef MULT_HI_EN
  assign prod = res_q;
`else
  // Upper operand halves are never stored; this only keeps them visibly consumed.
  logic unused_hi;
  assign unused_hi = ^{s_in[S_W-1:RES_W], a_full[PROD_W-1:RES_W]};
  assign prod      = {{(PROD_W - RES_W){1'b0}}, res_q};
`endif

  assign base    = 32'(idx_q) * 32'(SLICE_W);
  assign s_slice = s_q[base +: SLICE_W];
  assign a_slice = a_q[base +: SLICE_W];

  cfa_chunk_add #(.W(SLICE_W)) u_chunk (
    .a    (s_slice),
    .b    (a_slice),
    .cin  (carry_q),
    .sum  (sum_slice),
    .cout (cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ADD;
      ADD:     if (last_slice) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= '0;
      a_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else if (accept) begin
      s_q     <= s_in[RES_W-1:0];
      a_q     <= a_full[RES_W-1:0];
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else if (state_q == ADD) begin
      res_q[base +: SLICE_W] <= sum_slice;
      carry_q                <= cout;
      idx_q                  <= idx_q + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_cs_final_adder.sv
// Randomized and directed bench for cs_final_adder against a plain-arithmetic product model.
module tb_cs_final_adder;

`ifdef MULT_HI_EN
  localparam logic [63:0] MASK = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam int          LAT  = 4;
`else
  localparam logic [63:0] MASK = 64'h0000_0000_FFFF_FFFF;
  localparam int          LAT  = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [62:0] c_in = '0;
  logic [63:0] s_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] prod;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  cs_final_adder #(.CHUNK_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .c_in      (c_in),
    .s_in      (s_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%016h exp=0x%016h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [63:0] s, input logic [62:0] c);
    logic [63:0] c_val;
    c_val = {1'b0, c};
    return (s + c_val * 64'd2) & MASK;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pair and return #1 after the accepting edge.
  task automatic send(input logic [63:0] s, input logic [62:0] c);
    int w = 0;
    while (!in_ready && w < 64) begin
      tick();
      w++;
    end
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    s_in     = s;
    c_in     = c;
    exp_q.push_back(model(s, c));
    tick();
    in_valid = 1'b0;
    s_in     = $urandom();
    c_in     = '1;
  endtask

  // Wait for the product right after send, hold it for `hold` cycles, then take it.
  task automatic recv(input int hold, input string tag);
    int cnt = 0;
    logic [63:0] exp;
    while (!out_valid && cnt < 64) begin
      check({tag, "_busy_ready"}, 64'(in_ready), 64'd0);
      tick();
      cnt++;
    end
    check({tag, "_latency"}, 64'(cnt), 64'(LAT));
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
    check({tag, "_prod"}, prod, exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_hold_prod"}, prod, exp);
      check({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_taken_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_taken_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] rs;
    logic [62:0] rc;

    // Reset state
    tick();
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_prod", prod, 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors
    send(64'd5, 63'd3);                      recv(0, "basic");
    send(64'h0000_0000_0000_FFFF, 63'd1);    recv(1, "xslice");
    send(64'hFFFF_FFFF_FFFF_FFFF, 63'd1);    recv(0, "wrap");
    send(64'h0000_0000_FFFF_FFFF, 63'h4000_0000); recv(0, "lowhi");

    // Backpressure with a competing request that must wait until IDLE
    send(64'h1234_5678_9ABC_DEF0, 63'h0FED_CBA9_8765_4321);
    begin
      int cnt = 0;
      logic [63:0] exp;
      while (!out_valid && cnt < 64) begin
        tick();
        cnt++;
      end
      check("bp_latency", 64'(cnt), 64'(LAT));
      exp = exp_q.pop_front();
      in_valid = 1'b1;
      s_in     = 64'h0000_0000_0000_0100;
      c_in     = 63'h80;
      for (int i = 0; i < 5; i++) begin
        tick();
        check("bp_valid", 64'(out_valid), 64'd1);
        check("bp_prod", prod, exp);
        check("bp_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_idle_ready", 64'(in_ready), 64'd1);
      check("bp_idle_valid", 64'(out_valid), 64'd0);
      send(64'h0000_0000_0000_0100, 63'h80);
      recv(0, "bp_next");
    end

    // Reset while adding: the transaction is dropped
    send(64'hAAAA_AAAA_AAAA_AAAA, 63'h5555_5555);
    if (LAT > 2) tick();
    rst = 1'b1;
    #1;
    check("midrst_ready_now", 64'(in_ready), 64'd0);
    tick();
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_prod", prod, 64'd0);
    check("midrst_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    void'(exp_q.pop_back());
    #1;
    check("midrst_rel_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < LAT + 3; i++) begin
      tick();
      check("midrst_no_stale", 64'(out_valid), 64'd0);
    end
    out_ready = 1'b0;

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      rs = {$urandom(), $urandom()};
      rc = 63'({$urandom(), $urandom()});
      if ($urandom_range(0, 3) == 0) rs = 64'hFFFF_FFFF_FFFF_FFFF - {1'b0, rc} * 64'd2;
      send(rs, rc);
      recv($urandom_range(0, 3), "rand");
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
